// File: rtl/video_out_scheduler.sv
// +--------------------------------------------------------------------------+
// | video_out_scheduler: walks a feature buffer row by row for one video     |
// | frame and forwards the read data to the stream output stage.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module video_out_scheduler #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              system_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [9:0]        video_col_size,
  input  logic [9:0]        video_row_size,
  output logic              busy,
  output logic              done,
  output logic              video_output_req,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [47:0]       rd_data,
  output logic              video_valid,
  output logic [47:0]       video_data,
  input  logic              video_ready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [9:0]          col_size_q, col_size_d;
  logic [9:0]          row_size_q, row_size_d;
  logic [9:0]          col_q, col_d;
  logic [9:0]          row_q, row_d;
  logic [RD_LAT-1:0]   vpipe_q, vpipe_d;
  logic                rd_en_w;
  logic                pending_w;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    idx_d      = idx_q;
    col_size_d = col_size_q;
    row_size_d = row_size_q;
    col_d      = col_q;
    row_d      = row_q;
    rd_en_w    = (state_q == READ) && video_ready;

    // The last stage is being presented this cycle, so it no longer counts
    // as pending; this lets DONE line up with the cycle after the final beat.
    pending_w = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      pending_w = pending_w | vpipe_q[i];
    end

    vpipe_d    = '0;
    vpipe_d[0] = rd_en_w;
    for (int i = 1; i < RD_LAT; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if ((video_col_size != 10'd0) && (video_row_size != 10'd0)) begin
            base_d     = base_addr;
            col_size_d = video_col_size;
            row_size_d = video_row_size;
            idx_d      = '0;
            col_d      = '0;
            row_d      = '0;
            state_d    = REQ;
          end else begin
            state_d    = DONE;
          end
        end
      end
      REQ: state_d = READ;
      READ: begin
        if (rd_en_w) begin
          idx_d = idx_q + ADDR_W'(1);
          if (col_q == col_size_q - 10'd1) begin
            col_d = '0;
            if (row_q == row_size_q - 10'd1) begin
              state_d = DRAIN;
            end else begin
              row_d = row_q + 10'd1;
            end
          end else begin
            col_d = col_q + 10'd1;
          end
        end
      end
      DRAIN: begin
        if (!pending_w) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      idx_q      <= '0;
      col_size_q <= '0;
      row_size_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      vpipe_q    <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      col_size_q <= col_size_d;
      row_size_q <= row_size_d;
      col_q      <= col_d;
      row_q      <= row_d;
      vpipe_q    <= vpipe_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);
  assign video_output_req = (state_q == REQ);
  assign rd_en            = rd_en_w;
  assign rd_addr          = rd_en_w ? (base_q + idx_q) : '0;
  assign video_valid      = vpipe_q[RD_LAT-1];
  assign video_data       = rd_data;

endmodule

`default_nettype wire

// File: tb/tb_video_out_scheduler.sv
// +--------------------------------------------------------------------------+
// | tb_video_out_scheduler: directed self-checking bench for the scheduler.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_video_out_scheduler;

  localparam int ADDR_W = 16;
  localparam int LAT    = 2;

  logic              system_clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [9:0]        video_col_size = '0;
  logic [9:0]        video_row_size = '0;
  logic              busy, done, video_output_req, rd_en, video_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [47:0]       rd_data = '0;
  logic [47:0]       video_data;
  logic              video_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  video_out_scheduler #(.ADDR_W(ADDR_W), .RD_LAT(LAT)) dut (
    .system_clk       (system_clk),
    .rst              (rst),
    .start            (start),
    .base_addr        (base_addr),
    .video_col_size   (video_col_size),
    .video_row_size   (video_row_size),
    .busy             (busy),
    .done             (done),
    .video_output_req (video_output_req),
    .rd_en            (rd_en),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .video_valid      (video_valid),
    .video_data       (video_data),
    .video_ready      (video_ready)
  );

  always #5 system_clk = ~system_clk;

  // Per-run observations
  logic              log_rden [0:63];
  logic [ADDR_W-1:0] log_addr [0:63];
  logic              log_busy [0:63];
  logic              log_out0 [0:63];
  int n_req, req_cyc, n_done, done_cyc, n_busy;
  int                rd_cycs[$];
  logic [ADDR_W-1:0] rd_addrs[$];
  int                v_cycs[$];
  logic [47:0]       v_data[$];

  function automatic logic [47:0] pat(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5A5A};
  endfunction

  // Runs n cycles from a start pulse at cycle 0; the sizes/base are only
  // presented at cycle 0, junk values otherwise.
  task automatic run_frame(input int n, input logic [15:0] base, input logic [9:0] col,
                           input logic [9:0] row, input int stall_lo, input int stall_hi,
                           input int start2, input int rst_cyc);
    n_req = 0; req_cyc = -1; n_done = 0; done_cyc = -1; n_busy = 0;
    rd_cycs.delete(); rd_addrs.delete(); v_cycs.delete(); v_data.delete();
    @(posedge system_clk); #1;
    for (int c = 0; c < n; c++) begin
      start          = (c == 0) || (c == start2);
      base_addr      = (c == 0) ? base : 16'h5555;
      video_col_size = (c == 0) ? col : 10'd1;
      video_row_size = (c == 0) ? row : 10'd1;
      video_ready    = !(c >= stall_lo && c <= stall_hi);
      rst            = (c == rst_cyc);
      rd_data        = (c >= LAT && log_rden[c-LAT]) ? pat(log_addr[c-LAT]) : 48'h0BAD_0BAD_0BAD;
      @(negedge system_clk);
      log_rden[c] = rd_en;
      log_addr[c] = rd_addr;
      log_busy[c] = busy;
      log_out0[c] = !busy && !done && !video_output_req && !rd_en && !video_valid && (rd_addr == '0);
      if (video_output_req) begin n_req++; req_cyc = c; end
      if (done) begin n_done++; done_cyc = c; end
      if (busy) n_busy++;
      if (rd_en) begin rd_cycs.push_back(c); rd_addrs.push_back(rd_addr); end
      if (video_valid) begin v_cycs.push_back(c); v_data.push_back(video_data); end
      @(posedge system_clk); #1;
    end
    start = 1'b0; rst = 1'b0; video_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({busy, done, video_output_req, rd_en, video_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, video_output_req, rd_en, video_valid});
    end
    checks++;
    if (rd_addr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_addr: got %h expected 0000", rd_addr);
    end
    @(posedge system_clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    run_frame(20, 16'h0100, 10'd4, 10'd2, -1, -1, -1, -1);
    checks++;
    if (n_req != 1 || req_cyc != 1) begin
      errors++; $display("FAIL basic_req: got n=%0d cyc=%0d expected n=1 cyc=1", n_req, req_cyc);
    end
    checks++;
    if (rd_cycs.size() != 8) begin
      errors++; $display("FAIL basic_nreads: got %0d expected 8", rd_cycs.size());
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rd_cycs[k] != 2 + k || rd_addrs[k] !== 16'h0100 + 16'(k)) begin
        errors++;
        $display("FAIL basic_read%0d: got cyc=%0d addr=%h expected cyc=%0d addr=%h",
                 k, rd_cycs[k], rd_addrs[k], 2 + k, 16'h0100 + 16'(k));
      end
      checks++;
      if (v_cycs[k] != 4 + k || v_data[k] !== pat(16'h0100 + 16'(k))) begin
        errors++;
        $display("FAIL basic_valid%0d: got cyc=%0d data=%h expected cyc=%0d data=%h",
                 k, v_cycs[k], v_data[k], 4 + k, pat(16'h0100 + 16'(k)));
      end
    end
    checks++;
    if (v_cycs.size() != 8) begin
      errors++; $display("FAIL basic_nvalid: got %0d expected 8", v_cycs.size());
    end
    checks++;
    if (n_done != 1 || done_cyc != 12) begin
      errors++; $display("FAIL basic_done: got n=%0d cyc=%0d expected n=1 cyc=12", n_done, done_cyc);
    end
    checks++;
    if (n_busy != 12 || log_busy[0] !== 1'b0 || log_busy[13] !== 1'b0) begin
      errors++; $display("FAIL basic_busy: got cycles=%0d expected 12 (cycles 1..12)", n_busy);
    end
  endtask

  task automatic test_stall();
    int exp_rd[8] = '{2, 3, 7, 8, 9, 10, 11, 12};
    run_frame(24, 16'h0100, 10'd4, 10'd2, 4, 6, -1, -1);
    checks++;
    if (rd_cycs.size() != 8 || v_cycs.size() != 8) begin
      errors++; $display("FAIL stall_counts: got reads=%0d beats=%0d expected 8/8", rd_cycs.size(), v_cycs.size());
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rd_cycs[k] != exp_rd[k] || rd_addrs[k] !== 16'h0100 + 16'(k) ||
          v_cycs[k] != exp_rd[k] + LAT || v_data[k] !== pat(16'h0100 + 16'(k))) begin
        errors++;
        $display("FAIL stall_beat%0d: got rd=%0d addr=%h vcyc=%0d expected rd=%0d addr=%h vcyc=%0d",
                 k, rd_cycs[k], rd_addrs[k], v_cycs[k], exp_rd[k], 16'h0100 + 16'(k), exp_rd[k] + LAT);
      end
    end
    checks++;
    if (n_done != 1 || done_cyc != 15) begin
      errors++; $display("FAIL stall_done: got n=%0d cyc=%0d expected n=1 cyc=15", n_done, done_cyc);
    end
  endtask

  task automatic test_zero_size();
    run_frame(8, 16'h0300, 10'd0, 10'd2, -1, -1, -1, -1);
    checks++;
    if (n_done != 1 || done_cyc != 1) begin
      errors++; $display("FAIL zero_done: got n=%0d cyc=%0d expected n=1 cyc=1", n_done, done_cyc);
    end
    checks++;
    if (n_req != 0 || rd_cycs.size() != 0 || v_cycs.size() != 0) begin
      errors++; $display("FAIL zero_activity: got req=%0d reads=%0d beats=%0d expected 0/0/0",
                         n_req, rd_cycs.size(), v_cycs.size());
    end
  endtask

  task automatic test_addr_wrap();
    logic [15:0] exp_a[4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    run_frame(14, 16'hFFFE, 10'd4, 10'd1, -1, -1, -1, -1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_addrs[k] !== exp_a[k] || v_data[k] !== pat(exp_a[k])) begin
        errors++; $display("FAIL wrap_addr%0d: got %h expected %h", k, rd_addrs[k], exp_a[k]);
      end
    end
    checks++;
    if (rd_cycs.size() != 4 || n_done != 1 || done_cyc != 8) begin
      errors++; $display("FAIL wrap_done: got reads=%0d done_cyc=%0d expected 4/8", rd_cycs.size(), done_cyc);
    end
  endtask

  task automatic test_restart_ignored();
    run_frame(20, 16'h0100, 10'd4, 10'd2, -1, -1, 4, -1);
    checks++;
    if (rd_cycs.size() != 8 || n_req != 1 || n_done != 1 || done_cyc != 12) begin
      errors++; $display("FAIL restart_frame: got reads=%0d req=%0d done=%0d@%0d expected 8/1/1@12",
                         rd_cycs.size(), n_req, n_done, done_cyc);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rd_addrs[k] !== 16'h0100 + 16'(k)) begin
        errors++; $display("FAIL restart_addr%0d: got %h expected %h", k, rd_addrs[k], 16'h0100 + 16'(k));
      end
    end
  endtask

  task automatic test_mid_reset();
    run_frame(16, 16'h0100, 10'd4, 10'd2, -1, -1, -1, 5);
    checks++;
    if (log_out0[5] !== 1'b1) begin
      errors++; $display("FAIL midrst_outputs: got nonzero outputs during reset expected all 0");
    end
    checks++;
    if (rd_cycs.size() != 3 || v_cycs.size() != 1 || n_done != 0) begin
      errors++; $display("FAIL midrst_discard: got reads=%0d beats=%0d done=%0d expected 3/1/0",
                         rd_cycs.size(), v_cycs.size(), n_done);
    end
    run_frame(14, 16'h0200, 10'd2, 10'd2, -1, -1, -1, -1);
    checks++;
    if (rd_cycs.size() != 4 || v_cycs.size() != 4 || done_cyc != 8) begin
      errors++; $display("FAIL midrst_rerun: got reads=%0d beats=%0d done_cyc=%0d expected 4/4/8",
                         rd_cycs.size(), v_cycs.size(), done_cyc);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_addrs[k] !== 16'h0200 + 16'(k) || v_data[k] !== pat(16'h0200 + 16'(k))) begin
        errors++; $display("FAIL midrst_addr%0d: got %h expected %h", k, rd_addrs[k], 16'h0200 + 16'(k));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      log_rden[i] = 1'b0;
      log_addr[i] = '0;
      log_busy[i] = 1'b0;
      log_out0[i] = 1'b0;
    end
    test_reset();
    test_basic_frame();
    test_stall();
    test_zero_size();
    test_addr_wrap();
    test_restart_ignored();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
